// File: rtl/riscv_muldiv_if.sv
// Handshake bundle between the execute stage and the iterative mul/div unit.
// master: pipeline side (issues op/a/b, consumes result).
// slave : the mul/div unit.
// Signals: in_valid/in_ready request handshake, op (funct3), a/b operands,
//          out_valid/out_ready result handshake, result, busy.
interface riscv_muldiv_if #(
  parameter int W_SIZE = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [W_SIZE-1:0] a;
  logic [W_SIZE-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [W_SIZE-1:0] result;
  logic              busy;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit, one bit per cycle.
// Ports: clk, rst_n (async active-low), flush (sync kill),
//        bus (slave modport): request handshake, op/a/b, result handshake, busy.
// Flow: IDLE -> CALC (W_SIZE cycles) -> FIX (sign correction) -> DONE (hold).
// Divide-by-zero and signed overflow skip straight from IDLE to DONE.
module riscv_muldiv_unit #(
  parameter int  W_SIZE = 32,
  localparam int CNT_W  = $clog2(W_SIZE + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  riscv_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [W_SIZE-1:0] MIN_NEG = {1'b1, {(W_SIZE-1){1'b0}}};

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [2*W_SIZE-1:0] acc;
  logic [W_SIZE-1:0]   opnd;
  logic [W_SIZE-1:0]   result_q;
  logic [2:0]          op_q;
  logic                neg_a, neg_b;

  // Request decode
  logic              sgn_a_op, sgn_b_op, in_neg_a, in_neg_b;
  logic [W_SIZE-1:0] mag_a, mag_b;
  logic              div_zero, div_ovf, special, accept;
  logic [W_SIZE-1:0] special_res;

  always_comb begin
    sgn_a_op = (bus.op == 3'b001) || (bus.op == 3'b010) ||
               (bus.op == 3'b100) || (bus.op == 3'b110);
    sgn_b_op = (bus.op == 3'b001) || (bus.op == 3'b100) || (bus.op == 3'b110);
    in_neg_a = sgn_a_op & bus.a[W_SIZE-1];
    in_neg_b = sgn_b_op & bus.b[W_SIZE-1];
    mag_a    = in_neg_a ? -bus.a : bus.a;
    mag_b    = in_neg_b ? -bus.b : bus.b;
    div_zero = bus.op[2] & (bus.b == '0);
    // Only signed DIV/REM (op[0]=0) can overflow
    div_ovf  = bus.op[2] & ~bus.op[0] & (bus.a == MIN_NEG) & (bus.b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = bus.op[1] ? bus.a : '1;
    else          special_res = bus.op[1] ? '0 : bus.a;
    accept   = (state == IDLE) & bus.in_valid & ~flush;
  end

  // One iteration step. Multiply keeps the multiplier in the low half and
  // shifts the partial product down; divide shifts the dividend up into the
  // remainder (high half) and collects quotient bits in the low half.
  logic [W_SIZE:0]     mul_sum;
  logic [2*W_SIZE-1:0] mul_nxt;
  logic [W_SIZE:0]     div_hi;
  logic                div_ok;
  logic [W_SIZE-1:0]   div_rem;
  logic [2*W_SIZE-1:0] div_nxt;

  always_comb begin
    mul_sum = acc[0] ? ({1'b0, acc[2*W_SIZE-1:W_SIZE]} + {1'b0, opnd})
                     : {1'b0, acc[2*W_SIZE-1:W_SIZE]};
    mul_nxt = {mul_sum, acc[W_SIZE-1:1]};
    div_hi  = acc[2*W_SIZE-1:W_SIZE-1];
    div_ok  = div_hi >= {1'b0, opnd};
    div_rem = div_hi[W_SIZE-1:0] - opnd;
    if (div_ok) div_nxt = {div_rem, acc[W_SIZE-2:0], 1'b1};
    else        div_nxt = {acc[2*W_SIZE-2:W_SIZE-1], acc[W_SIZE-2:0], 1'b0};
  end

  // Sign correction and result selection
  logic [2*W_SIZE-1:0] prod;
  logic [W_SIZE-1:0]   quot, rem, fix_res;

  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    quot = (neg_a ^ neg_b) ? -acc[W_SIZE-1:0] : acc[W_SIZE-1:0];
    rem  = neg_a ? -acc[2*W_SIZE-1:W_SIZE] : acc[2*W_SIZE-1:W_SIZE];
    if (op_q[2])            fix_res = op_q[1] ? rem : quot;
    else if (op_q == 3'b000) fix_res = prod[W_SIZE-1:0];
    else                    fix_res = prod[2*W_SIZE-1:W_SIZE];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
    end else if (accept) begin
      op_q  <= bus.op;
      neg_a <= in_neg_a;
      neg_b <= in_neg_b;
      cnt   <= CNT_W'(W_SIZE);
      acc   <= bus.op[2] ? {{W_SIZE{1'b0}}, mag_a} : {{W_SIZE{1'b0}}, mag_b};
      opnd  <= bus.op[2] ? mag_b : mag_a;
      if (special) result_q <= special_res;
    end else if (state == CALC && !flush) begin
      acc <= op_q[2] ? div_nxt : mul_nxt;
      cnt <= cnt - CNT_W'(1);
    end else if (state == FIX && !flush) begin
      result_q <= fix_res;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == CALC) || (state == FIX);
  assign bus.result    = result_q;

endmodule

// File: doc/riscv_muldiv_unit.md
# riscv_muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in operand width, sitting beside the single-cycle ALU in the execute stage. It accepts one operation per valid/ready handshake and computes it at one bit per cycle. Signs are corrected in a dedicated cycle, and divide-by-zero and signed overflow resolve in one cycle. The result is held until the pipeline consumes it, and an in-flight operation can be killed on a pipeline flush.

## Interface
- W_SIZE, 32, operand/result width; must be ≥ 4 and even.
- CNT_W, $clog2(W_SIZE+1), iteration counter width; derived, not overridden.

- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- flush  input  1  synchronous kill of any accepted or in-flight operation.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high only in IDLE.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  W_SIZE  rs1 operand.
- b  input  W_SIZE  rs2 operand.
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- result  output  W_SIZE  result; stable while out_valid.
- busy  output  1  state is CALC or FIX.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC when in_valid & in_ready and no special case.
  - Latch op and operand magnitudes, recording neg_a and neg_b.
  - neg_a is meaningful for MULH, MULHSU, DIV and REM; neg_b for MULH, DIV and REM. Operands of all other ops are treated as unsigned.
  - Load counter with W_SIZE.
- Special cases in IDLE go straight to DONE:
  - Divide by zero (op[2]=1, b=0): DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (DIV/REM, a=1<<(W_SIZE-1), b=all-ones): DIV gives a; REM gives 0.
- CALC, multiply: shift-add on a 2·W_SIZE-bit accumulator, one multiplier bit per cycle.
- CALC, divide: restoring divide, one quotient bit per cycle.
- CALC ends when the counter decrements from 1 to 0; then → FIX.
- FIX: apply sign correction and select the result, → DONE.
  - Product is negated when neg_a^neg_b. MUL returns the low half; MULH, MULHSU and MULHU return the high half.
  - Quotient is negated when neg_a^neg_b. Remainder is negated when neg_a.
- DONE: out_valid=1 and result is held. → IDLE on out_ready.
- All arithmetic is modulo 2^W_SIZE except the 2·W_SIZE product accumulator; no overflow flags.
- flush=1 in any state → IDLE at the next edge, with no result produced.
  - flush has priority over in_valid and out_ready.
  - A request presented in the same cycle as flush is not accepted.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0.
- Reset asserted mid-operation aborts immediately (asynchronously); no partial result is ever visible.

## Timing
- Normal op accepted at edge N:
  - CALC occupies edges N+1 … N+W_SIZE.
  - FIX at edge N+W_SIZE+1.
  - out_valid first high after edge N+W_SIZE+1. Latency is W_SIZE+2 cycles; 34 for W_SIZE=32.
- Special-case op accepted at edge N: out_valid high after edge N.
- in_ready is deasserted from the cycle after acceptance until the cycle after the DONE → IDLE edge.
  - No back-to-back accept in the same cycle as result consumption.
  - Maximum throughput is one op per W_SIZE+3 cycles.
- result, out_valid, in_ready and busy are purely registered-state decodes; no combinational path from inputs to outputs.
- out_ready is sampled only in DONE; out_ready=1 while out_valid=0 has no effect.
- in_valid held high while in_ready=0 has no effect. The request must be re-presented.

## Test plan
- Multiply, W_SIZE=32:
  - MUL a=7, b=0xFFFFFFFD → 0xFFFFFFEB, out_valid exactly 34 cycles after accept.
  - MULH a=b=0x80000000 → 0x40000000.
  - MULHU a=b=0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU a=0xFFFFFFFF, b=2 → 0xFFFFFFFF.
- Divide/remainder:
  - DIV a=0xFFFFFFF9 (-7), b=2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
- Special cases, out_valid one cycle after accept:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM 0x80000000/0xFFFFFFFF → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0; out_ready=1 → in_ready=1 the next cycle.
- Flush:
  - flush at CALC cycle 5 → IDLE next edge, no out_valid; a following MUL 3×4 → 12.
  - flush together with in_valid in IDLE → not accepted.
- Reset: rst_n low mid-CALC → immediate IDLE, out_valid=0, result=0. Repeat at W_SIZE=8: MULHU 0xFF×0xFF → 0xFE, latency 10.
